morse_rx: RTL and testbench

Receive-side counterpart of the Morse transmitter. It samples a serial on/off Morse line once per clk_morse tick, where one tick equals one Morse time unit. It classifies mark and space run lengths into dots, dashes, character gaps and word gaps, and emits one ASCII byte per decoded character on a valid/ready output. The output feeds an async FIFO toward the system clock domain; that FIFO lives outside this block.

---
 rtl/morse_pkg.sv | 25 ++
 rtl/morse2ascii.sv | 58 +++++
 rtl/morse_rx.sv | 177 +++++++++++++++++
 tb/tb_morse_rx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions: unit timing, state encoding and decode key.
package morse_pkg;

    localparam int DOT      = 1;
    localparam int DASH     = 3;
    localparam int ELEM_GAP = 1;
    localparam int CHAR_GAP = 3;
    localparam int WORD_GAP = 7;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MARK  = 2'd1;
    localparam logic [1:0] ST_SPACE = 2'd2;

    typedef struct packed {
        logic [2:0] len;
        logic [5:0] pattern;
    } morse_key_t;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/morse2ascii.sv
// Combinational Morse-to-ASCII lookup; 1 = dash, first element is the
// most significant used bit. Unknown patterns return 8'h00.
module morse2ascii
    import morse_pkg::*;
(
    input  morse_key_t i_key,
    output logic [7:0] o_ascii
);

    always_comb begin
        o_ascii = 8'h00;
        case (i_key)
            {3'd2, 6'b000001}: o_ascii = "A";
            {3'd4, 6'b001000}: o_ascii = "B";
            {3'd4, 6'b001010}: o_ascii = "C";
            {3'd3, 6'b000100}: o_ascii = "D";
            {3'd1, 6'b000000}: o_ascii = "E";
            {3'd4, 6'b000010}: o_ascii = "F";
            {3'd3, 6'b000110}: o_ascii = "G";
            {3'd4, 6'b000000}: o_ascii = "H";
            {3'd2, 6'b000000}: o_ascii = "I";
            {3'd4, 6'b000111}: o_ascii = "J";
            {3'd3, 6'b000101}: o_ascii = "K";
            {3'd4, 6'b000100}: o_ascii = "L";
            {3'd2, 6'b000011}: o_ascii = "M";
            {3'd2, 6'b000010}: o_ascii = "N";
            {3'd3, 6'b000111}: o_ascii = "O";
            {3'd4, 6'b000110}: o_ascii = "P";
            {3'd4, 6'b001101}: o_ascii = "Q";
            {3'd3, 6'b000010}: o_ascii = "R";
            {3'd3, 6'b000000}: o_ascii = "S";
            {3'd1, 6'b000001}: o_ascii = "T";
            {3'd3, 6'b000001}: o_ascii = "U";
            {3'd4, 6'b000001}: o_ascii = "V";
            {3'd3, 6'b000011}: o_ascii = "W";
            {3'd4, 6'b001001}: o_ascii = "X";
            {3'd4, 6'b001011}: o_ascii = "Y";
            {3'd4, 6'b001100}: o_ascii = "Z";
            {3'd5, 6'b011111}: o_ascii = "0";
            {3'd5, 6'b001111}: o_ascii = "1";
            {3'd5, 6'b000111}: o_ascii = "2";
            {3'd5, 6'b000011}: o_ascii = "3";
            {3'd5, 6'b000001}: o_ascii = "4";
            {3'd5, 6'b000000}: o_ascii = "5";
            {3'd5, 6'b010000}: o_ascii = "6";
            {3'd5, 6'b011000}: o_ascii = "7";
            {3'd5, 6'b011100}: o_ascii = "8";
            {3'd5, 6'b011110}: o_ascii = "9";
            {3'd6, 6'b010101}: o_ascii = ".";
            {3'd6, 6'b110011}: o_ascii = ",";
            {3'd6, 6'b001100}: o_ascii = "?";
            {3'd5, 6'b010010}: o_ascii = "/";
            {3'd5, 6'b010001}: o_ascii = "=";
            default:           o_ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/morse_rx.sv
// Morse receiver: classifies mark/space run lengths on the synchronised
// line and emits one ASCII byte per character on a valid/ready output.
module morse_rx
    import morse_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DASH_MIN     = (DOT + DASH) / 2,
    parameter int CHAR_GAP_MIN = (ELEM_GAP + CHAR_GAP) / 2,
    parameter int WORD_GAP_MIN = (CHAR_GAP + WORD_GAP) / 2,
    parameter int MAX_ELEMS    = 6
) (
    input  logic       clk_morse,
    input  logic       arst_n,
    input  logic       morse_in,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       err_decode,
    output logic       err_overflow
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    logic [1:0]           r_state, w_state_nx;
    logic [2:0]           r_mark_cnt, w_mark_nx;
    logic [2:0]           r_space_cnt, w_space_nx;
    logic [2:0]           r_elem_cnt, w_elem_nx;
    logic [MAX_ELEMS-1:0] r_pattern, w_pat_nx;
    logic                 r_overrun, w_ovr_nx;
    logic                 r_word_pending, w_wp_nx;

    logic       w_emit;
    logic       w_dec_err;
    logic [7:0] w_emit_byte;
    logic [7:0] w_ascii;
    morse_key_t w_key;

    logic [7:0] r_ascii;
    logic       r_valid;
    logic       r_err_decode;
    logic       r_err_overflow;

    always_ff @(posedge clk_morse or negedge arst_n) begin
        if (!arst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], morse_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    assign w_key.len     = r_elem_cnt;
    assign w_key.pattern = 6'(r_pattern);

    morse2ascii u_dec (
        .i_key   (w_key),
        .o_ascii (w_ascii)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_mark_nx   = r_mark_cnt;
        w_space_nx  = r_space_cnt;
        w_elem_nx   = r_elem_cnt;
        w_pat_nx    = r_pattern;
        w_ovr_nx    = r_overrun;
        w_wp_nx     = r_word_pending;
        w_emit      = 1'b0;
        w_emit_byte = 8'h00;
        w_dec_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nx = ST_MARK;
                    w_mark_nx  = 3'd1;
                end
            end
            ST_MARK: begin
                if (w_s) begin
                    w_mark_nx = sat_inc3(r_mark_cnt);
                end else begin
                    if (r_elem_cnt == 3'(MAX_ELEMS)) begin
                        w_ovr_nx = 1'b1;
                    end else begin
                        w_pat_nx  = {r_pattern[MAX_ELEMS-2:0],
                                     (r_mark_cnt >= 3'(DASH_MIN))};
                        w_elem_nx = r_elem_cnt + 3'd1;
                    end
                    w_state_nx = ST_SPACE;
                    w_space_nx = 3'd1;
                end
            end
            ST_SPACE: begin
                if (w_s) begin
                    w_state_nx = ST_MARK;
                    w_mark_nx  = 3'd1;
                end else begin
                    w_space_nx = sat_inc3(r_space_cnt);
                    if (w_space_nx == 3'(CHAR_GAP_MIN)) begin
                        if (r_overrun || (w_ascii == 8'h00)) begin
                            w_dec_err = 1'b1;
                        end else begin
                            w_emit      = 1'b1;
                            w_emit_byte = w_ascii;
                        end
                        w_pat_nx  = '0;
                        w_elem_nx = 3'd0;
                        w_ovr_nx  = 1'b0;
                        w_wp_nx   = 1'b1;
                    end
                    // word gap ends the space run whether or not a word is open
                    if (w_space_nx == 3'(WORD_GAP_MIN)) begin
                        if (r_word_pending) begin
                            w_emit      = 1'b1;
                            w_emit_byte = ASCII_SPACE;
                        end
                        w_wp_nx    = 1'b0;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_morse or negedge arst_n) begin
        if (!arst_n) begin
            r_state        <= ST_IDLE;
            r_mark_cnt     <= 3'd0;
            r_space_cnt    <= 3'd0;
            r_elem_cnt     <= 3'd0;
            r_pattern      <= '0;
            r_overrun      <= 1'b0;
            r_word_pending <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_mark_cnt     <= w_mark_nx;
            r_space_cnt    <= w_space_nx;
            r_elem_cnt     <= w_elem_nx;
            r_pattern      <= w_pat_nx;
            r_overrun      <= w_ovr_nx;
            r_word_pending <= w_wp_nx;
        end
    end

    always_ff @(posedge clk_morse or negedge arst_n) begin
        if (!arst_n) begin
            r_ascii        <= 8'h00;
            r_valid        <= 1'b0;
            r_err_decode   <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_err_decode   <= w_dec_err;
            r_err_overflow <= 1'b0;
            if (w_emit) begin
                if (!r_valid || ascii_ready) begin
                    r_ascii <= w_emit_byte;
                    r_valid <= 1'b1;
                end else begin
                    r_err_overflow <= 1'b1;
                end
            end else if (r_valid && ascii_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ascii_out    = r_ascii;
    assign ascii_valid  = r_valid;
    assign err_decode   = r_err_decode;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_morse_rx.sv
// Bench for morse_rx: run-length stimulus checked against a
// string-level Morse model and directed timing/backpressure cases.
module tb_morse_rx;

    localparam int SYNC = 2;
    localparam int DMIN = 2;
    localparam int CMIN = 2;
    localparam int WMIN = 5;
    localparam int MAXE = 6;

    logic       clk_morse = 1'b0;
    logic       arst_n = 1'b0;
    logic       morse_in = 1'b0;
    logic       ascii_ready = 1'b0;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       err_decode;
    logic       err_overflow;

    morse_rx #(
        .SYNC_STAGES  (SYNC),
        .DASH_MIN     (DMIN),
        .CHAR_GAP_MIN (CMIN),
        .WORD_GAP_MIN (WMIN),
        .MAX_ELEMS    (MAXE)
    ) dut (
        .clk_morse    (clk_morse),
        .arst_n       (arst_n),
        .morse_in     (morse_in),
        .ascii_out    (ascii_out),
        .ascii_valid  (ascii_valid),
        .ascii_ready  (ascii_ready),
        .err_decode   (err_decode),
        .err_overflow (err_overflow)
    );

    always #5 clk_morse = ~clk_morse;

    int n_chk = 0;
    int n_pass = 0;
    int obs_q[$];
    int exp_q[$];
    int ovf_cnt = 0;
    int dec_cnt = 0;
    int run_val[$];
    int run_len[$];
    int tbl[string];
    string codes[$];

    string alnum[36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....",
        "--...", "---..", "----."
    };

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    // event stream: bytes taken by the consumer, 256 for a decode error
    always @(negedge clk_morse) begin
        if (arst_n) begin
            if (err_decode) begin
                obs_q.push_back(256);
                dec_cnt++;
            end
            if (err_overflow) ovf_cnt++;
            if (ascii_valid && ascii_ready) obs_q.push_back(int'(ascii_out));
        end
    end

    task automatic tick();
        @(posedge clk_morse);
        #1;
    endtask

    task automatic clear();
        obs_q.delete();
        exp_q.delete();
        run_val.delete();
        run_len.delete();
        ovf_cnt = 0;
        dec_cnt = 0;
    endtask

    task automatic add(input int v, input int l);
        run_val.push_back(v);
        run_len.push_back(l);
    endtask

    // dash_len 0 picks a random dash length in the tolerated range
    task automatic add_char(input string code, input int gap, input int dash_len);
        for (int j = 0; j < code.len(); j++) begin
            if (code.getc(j) == "-")
                add(1, (dash_len == 0) ? int'($urandom_range(2, 7)) : dash_len);
            else
                add(1, 1);
            if (j != code.len() - 1) add(0, 1);
        end
        add(0, gap);
    endtask

    function automatic void model();
        string cur;
        bit wp;
        cur = "";
        wp = 1'b0;
        for (int i = 0; i < run_val.size(); i++) begin
            if (run_val[i] != 0) begin
                if (run_len[i] >= DMIN) cur = {cur, "-"};
                else cur = {cur, "."};
            end else begin
                if (cur.len() > 0 && run_len[i] >= CMIN) begin
                    if (cur.len() <= MAXE && tbl.exists(cur)) exp_q.push_back(tbl[cur]);
                    else exp_q.push_back(256);
                    cur = "";
                    wp = 1'b1;
                end
                if (wp && cur.len() == 0 && run_len[i] >= WMIN) begin
                    exp_q.push_back(32);
                    wp = 1'b0;
                end
            end
        end
    endfunction

    task automatic drive_runs();
        for (int i = 0; i < run_val.size(); i++) begin
            morse_in = (run_val[i] != 0);
            repeat (run_len[i]) tick();
        end
        morse_in = 1'b0;
        repeat (SYNC + 4) tick();
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, "_ovf"}, ovf_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k1, k2, b1;
        string p;

        for (int i = 0; i < 26; i++) tbl[alnum[i]] = 65 + i;
        for (int i = 26; i < 36; i++) tbl[alnum[i]] = 48 + i - 26;
        tbl[".-.-.-"] = 8'h2e;
        tbl["--..--"] = 8'h2c;
        tbl["..--.."] = 8'h3f;
        tbl["-..-."]  = 8'h2f;
        tbl["-...-"]  = 8'h3d;
        foreach (tbl[key]) codes.push_back(key);

        // reset state
        repeat (3) tick();
        check("rst_out", ascii_out, 0);
        check("rst_valid", ascii_valid, 0);
        check("rst_errdec", err_decode, 0);
        check("rst_errovf", err_overflow, 0);
        @(negedge clk_morse);
        arst_n = 1'b1;
        repeat (2) tick();

        // 'E' latency: count edges from the last mark edge on the raw line
        clear();
        ascii_ready = 1'b1;
        k1 = -1;
        k2 = -1;
        b1 = -1;
        morse_in = 1'b1;
        tick();
        morse_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ascii_valid && k1 < 0) begin
                k1 = k;
                b1 = int'(ascii_out);
            end else if (ascii_valid && ascii_out == 8'h20 && k2 < 0) begin
                k2 = k;
            end
        end
        check("e_latency", k1, SYNC + CMIN);
        check("e_byte", b1, 8'h45);
        check("e_space_latency", k2, SYNC + WMIN);
        check("e_errdec", dec_cnt, 0);
        check("e_errovf", ovf_cnt, 0);

        // SOS at nominal timing
        clear();
        add_char("...", 3, 3);
        add_char("---", 3, 3);
        add_char("...", 7, 3);
        exp_q = '{8'h53, 8'h4f, 8'h53, 8'h20};
        drive_runs();
        compare("sos");

        // dash tolerance
        clear();
        add_char("-", 3, 2);
        add_char("-", 3, 3);
        add_char("-", 3, 7);
        add_char(".", 10, 3);
        exp_q = '{8'h54, 8'h54, 8'h54, 8'h45, 8'h20};
        drive_runs();
        compare("dash");

        // too many elements, then a normal character
        clear();
        add_char(".......", 3, 3);
        add_char(".-", 10, 3);
        exp_q = '{256, 8'h41, 8'h20};
        drive_runs();
        compare("overrun");
        check("overrun_decpulses", dec_cnt, 1);

        // backpressure: E held, T and the word space both dropped
        clear();
        ascii_ready = 1'b0;
        add_char(".", 3, 3);
        add_char("-", 10, 3);
        drive_runs();
        check("bp_valid", ascii_valid, 1);
        check("bp_held", ascii_out, 8'h45);
        check("bp_ovf", ovf_cnt, 2);
        check("bp_dec", dec_cnt, 0);
        check("bp_taken", obs_q.size(), 0);
        ascii_ready = 1'b1;
        repeat (4) tick();
        check("bp_release_n", obs_q.size(), 1);
        if (obs_q.size() > 0) check("bp_release_byte", obs_q[0], 8'h45);
        check("bp_release_valid", ascii_valid, 0);

        // reset during the second element of 'A' with a byte held
        clear();
        ascii_ready = 1'b0;
        add_char(".", 3, 3);
        drive_runs();
        check("mrst_pre_valid", ascii_valid, 1);
        morse_in = 1'b1;
        tick();
        morse_in = 1'b0;
        tick();
        morse_in = 1'b1;
        repeat (2) tick();
        arst_n = 1'b0;
        #2;
        check("mrst_valid", ascii_valid, 0);
        check("mrst_out", ascii_out, 0);
        check("mrst_errdec", err_decode, 0);
        check("mrst_errovf", err_overflow, 0);
        morse_in = 1'b0;
        @(negedge clk_morse);
        arst_n = 1'b1;
        clear();
        ascii_ready = 1'b1;
        repeat (10) tick();
        check("mrst_after_n", obs_q.size(), 0);
        check("mrst_after_valid", ascii_valid, 0);

        // randomised traffic
        clear();
        for (int c = 0; c < 60; c++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(WMIN, 9))
                                              : int'($urandom_range(CMIN, WMIN - 1));
            if ($urandom_range(0, 4) == 0) begin
                p = "";
                for (int j = 0; j < int'($urandom_range(1, 8)); j++) begin
                    if ($urandom_range(0, 1) != 0) p = {p, "-"};
                    else p = {p, "."};
                end
            end else begin
                p = codes[$urandom_range(0, codes.size() - 1)];
            end
            add_char(p, gap, 0);
        end
        add(0, 10);
        model();
        drive_runs();
        compare("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
